// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only instruction cache with a block-fill FSM
//   CLK, RESET (async active-low)         clock and reset
//   PC -> INSTRUCTION, BUSYWAIT           cpu side: word at PC, stall while a miss is serviced
//   MEM_READ, MEM_ADDRESS                 memory side: block read request and block address
//   MEM_READDATA, MEM_BUSYWAIT            memory side: 128-bit block and busy handshake
module instruction_cache #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [ADDR_BITS-5:0]  MEM_ADDRESS,
    input  logic [127:0]          MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);
    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [127:0]           data_q [LINES];
    logic [ADDR_BITS-5:0]   miss_q;
    logic [127:0]           fill_q;

    logic [1:0]             offset;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [ADDR_BITS-5:0]   pc_blk;
    logic [INDEX_BITS-1:0]  miss_idx;
    logic [TAG_BITS-1:0]    miss_tag;
    logic                   hit;
    logic                   unused_pc;

    assign offset      = PC[3:2];
    assign index       = PC[3+INDEX_BITS:4];
    assign tag         = PC[ADDR_BITS-1:4+INDEX_BITS];
    assign pc_blk      = PC[ADDR_BITS-1:4];
    assign miss_idx    = miss_q[INDEX_BITS-1:0];
    assign miss_tag    = miss_q[ADDR_BITS-5:INDEX_BITS];
    assign unused_pc   = ^{PC[31:ADDR_BITS], PC[1:0]};
    assign hit         = valid_q[index] && tag_q[index] == tag;
    assign INSTRUCTION = hit ? data_q[index][{offset, 5'b0} +: 32] : 32'h0;

    always_comb begin
        state_d     = state_q;
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = !hit;
                state_d  = hit ? IDLE : FETCH;
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_q;
                state_d     = MEM_BUSYWAIT ? FETCH : UPDATE;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the valid bits need clearing; stale tags/data are unreachable until refilled.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            miss_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && !hit) miss_q <= pc_blk;
            if (state_q == FETCH && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
            if (state_q == UPDATE) valid_q[miss_idx] <= 1'b1;
        end
    end

    // Fill always targets the captured miss address, never the live PC.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_q;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: randomized self-checking bench against a line-level cache model
module tb_instruction_cache;
    logic         clk;
    logic         reset;
    logic [31:0]  pc;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    instruction_cache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
        .CLK(clk),
        .RESET(reset),
        .PC(pc),
        .INSTRUCTION(instruction),
        .BUSYWAIT(busywait),
        .MEM_READ(mem_read),
        .MEM_ADDRESS(mem_address),
        .MEM_READDATA(mem_readdata),
        .MEM_BUSYWAIT(mem_busywait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          vectors;
    int          miscompares;
    logic [31:0] mem [256];
    logic        mvalid [8];
    logic [2:0]  mtag [8];
    int          lat_cur;
    int          busy_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory: busy for lat_cur cycles after a request appears, then presents the block.
    task automatic mem_drive();
        if (mem_read) begin
            if (busy_cnt < lat_cur) begin
                mem_busywait = 1'b1;
                busy_cnt++;
            end else begin
                mem_busywait = 1'b0;
                mem_readdata = {mem[{mem_address, 2'd3}], mem[{mem_address, 2'd2}],
                                mem[{mem_address, 2'd1}], mem[{mem_address, 2'd0}]};
            end
        end else begin
            busy_cnt     = 0;
            mem_busywait = 1'b0;
            mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    endtask

    // One cpu access: hold PC until BUSYWAIT drops, then check stall length and word.
    task automatic access(input logic [31:0] a, input int lat);
        int         busy;
        int         reads;
        logic       hit;
        logic [5:0] blk;
        blk     = a[9:4];
        hit     = mvalid[blk[2:0]] && mtag[blk[2:0]] == blk[5:3];
        lat_cur = lat;
        busy    = 0;
        reads   = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            pc = a;
            mem_drive();
            #1;
            if (!busywait) break;
            busy++;
            if (mem_read) begin
                reads++;
                chk("mem_addr", {26'd0, mem_address}, {26'd0, blk});
            end else begin
                chk("addr_nofetch", {26'd0, mem_address}, 32'd0);
            end
            chk("instr_stall", instruction, 32'd0);
        end
        chk("busy_cycles", busy, hit ? 0 : lat + 3);
        chk("read_cycles", reads, hit ? 0 : lat + 1);
        chk("instr", instruction, mem[a[9:2]]);
        chk("rd_on_hit", {31'd0, mem_read}, 32'd0);
        chk("addr_on_hit", {26'd0, mem_address}, 32'd0);
        mvalid[blk[2:0]] = 1'b1;
        mtag[blk[2:0]]   = blk[5:3];
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        int reads;
        lat_cur = 6;
        reads   = 0;
        for (int c = 0; c < 64 && reads < 2; c++) begin
            @(negedge clk);
            pc = a;
            mem_drive();
            #1;
            if (mem_read) reads++;
        end
        chk("rst_reads_seen", reads, 2);
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_addr", {26'd0, mem_address}, 32'd0);
        chk("rst_busywait", {31'd0, busywait}, 32'd1);
        model_clear();
        @(posedge clk);
        #2 reset = 1'b1;
        access(a, 2);
    endtask

    initial begin
        logic [31:0] a;
        vectors      = 0;
        miscompares  = 0;
        busy_cnt     = 0;
        lat_cur      = 0;
        reset        = 1'b0;
        pc           = 32'd0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0] = 32'h04030201;
        mem[1] = 32'h08070605;
        mem[2] = 32'h0c0b0a09;
        mem[3] = 32'h100f0e0d;
        model_clear();

        #12;
        chk("reset_busywait", {31'd0, busywait}, 32'd1);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset_mem_addr", {26'd0, mem_address}, 32'd0);
        chk("reset_instr", instruction, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        access(32'd0, 5);
        access(32'd4, 3);
        access(32'd8, 3);
        access(32'd12, 3);
        access(32'd16, 2);
        access(32'd20, 2);
        access(32'd24, 2);
        access(32'd28, 2);
        access(32'd0, 2);
        access(32'd128, 3);
        access(32'd0, 1);
        reset_mid_fill(32'h40);
        access(32'h200, 0);
        access(32'h204, 0);

        for (int n = 0; n < 300; n++) begin
            a      = $urandom();
            a[9:4] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            access(a, $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache placed between the cpu's PC output and the instruction memory.
- Returns the 32-bit word at PC on a hit with no stall.
- On a miss it asserts BUSYWAIT to stall the cpu, fetches a 128-bit block from instruction memory over a request/busy handshake, and installs the block. The lookup then hits.

Parameters:
- ADDR_BITS, 10, byte-address bits of PC used; instruction memory is 2^ADDR_BITS bytes.
- INDEX_BITS, 3, line index width; 2^INDEX_BITS lines of 16 bytes (4 words) each.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- PC  input  32  byte address of the requested instruction from the cpu
- INSTRUCTION  output  32  instruction word at PC, valid while BUSYWAIT=0
- BUSYWAIT  output  1  stall request to the cpu; cpu holds PC while high
- MEM_READ  output  1  read request to instruction memory
- MEM_ADDRESS  output  ADDR_BITS-4  block address of the request
- MEM_READDATA  input  128  block data; word 0 in bits [31:0]
- MEM_BUSYWAIT  input  1  memory busy; data valid on the first cycle it is low after a request

Behaviour:
- Address split, using PC[ADDR_BITS-1:0]:
  - bits[1:0] ignored
  - offset = [3:2]
  - index = [3+INDEX_BITS:4]
  - tag = remaining upper bits
  - PC bits above ADDR_BITS are ignored.
- Per-line storage: valid bit, tag, 128-bit data.
- hit = valid[index] && tag[index]==PC tag, evaluated combinationally; #1 modelling delay permitted, no more.
- INSTRUCTION = data[index] word selected by offset when hit; 32'h0 otherwise.
- FSM states and transitions:
  - IDLE: BUSYWAIT = !hit, MEM_READ=0. On the rising edge with !hit, capture {tag,index} of PC into a miss register and go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS = captured {tag,index}, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. On the first rising edge with MEM_BUSYWAIT=0, go to UPDATE.
  - UPDATE: BUSYWAIT=1, MEM_READ=0. On the rising edge, write MEM_READDATA (registered at FETCH exit) into the captured index, set its tag and valid=1, go to IDLE.
- Miss latency:
  - Memory busy for N cycles after the request gives BUSYWAIT high for N+3 cycles (1 IDLE-detect + N+1 FETCH + 1 UPDATE).
  - The lookup hits on the first IDLE cycle after UPDATE.
- Hit latency: 0 cycles; BUSYWAIT stays low and the cpu advances every cycle.
- MEM_ADDRESS is 0 outside FETCH. MEM_READ is never asserted in IDLE or UPDATE.
- The fill always uses the captured address. If PC changes during FETCH/UPDATE (a cpu protocol violation), the fill still completes to the captured line, and the new PC is then looked up in IDLE.
- A miss that replaces a valid line overwrites it with no writeback, since the cache is read-only.
- Reset (RESET=0), asserted at any time including mid-FETCH:
  - Immediately clears all valid bits, state=IDLE, MEM_READ=0, MEM_ADDRESS=0.
  - BUSYWAIT follows the IDLE rule (=1 because no line is valid).
  - Tag and data arrays need not be cleared.
  - Any in-flight memory response is ignored.
- Reset release: the first edge with RESET=1 performs a normal IDLE lookup.
- Simultaneous events: a hit in IDLE on the same edge as reset release is served normally. MEM_BUSYWAIT falling in the same cycle FETCH is entered counts as completion on the next edge.

Test Plan:
- Cold miss: release reset with PC=0, memory busy 5 cycles, block 0 = {32'h04030201 at word0..}. Required: BUSYWAIT high for 8 cycles, MEM_ADDRESS=0, then INSTRUCTION=word0 with BUSYWAIT=0.
- Sequential hits: after the fill, PC=4,8,12 on consecutive cycles. Required: BUSYWAIT stays 0, INSTRUCTION = words 1, 2, 3, MEM_READ stays 0.
- Next-block miss: PC=16. Required: one fill with MEM_ADDRESS=1, then hits for PC=16..28. Index 0 stays valid, so PC=0 hits afterwards.
- Conflict eviction: PC=128 maps to index 0 with tag 1. Required: miss, MEM_ADDRESS=8, line replaced. A subsequent PC=0 misses again with MEM_ADDRESS=0.
- Reset mid-fill: assert RESET=0 two cycles into FETCH. Required: MEM_READ drops immediately. After release, the same PC misses again and issues a fresh request.
- Back-to-back memory ready: MEM_BUSYWAIT=0 throughout. Required: miss costs exactly 3 BUSYWAIT cycles, and the correct word is returned.
